// File: rtl/bcd_display_pkg.sv
// Shared types, constants and helpers for the decimal seven-segment display path.
package bcd_display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [7:0] SEG_BLANK   = 8'hFF;
   localparam int         MAX_DISPLAY = 9999;

   // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 goes dark.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] pattern;
      case (digit)
         4'd0:    pattern = 7'h40;
         4'd1:    pattern = 7'h79;
         4'd2:    pattern = 7'h24;
         4'd3:    pattern = 7'h30;
         4'd4:    pattern = 7'h19;
         4'd5:    pattern = 7'h12;
         4'd6:    pattern = 7'h02;
         4'd7:    pattern = 7'h78;
         4'd8:    pattern = 7'h00;
         4'd9:    pattern = 7'h10;
         default: pattern = 7'h7F;
      endcase
      return pattern;
   endfunction

   function automatic logic [15:0] dd_adjust(input logic [15:0] bcd);
      logic [15:0] adjusted;
      for (int k = 0; k < 4; k++) begin
         if (bcd[4*k +: 4] >= 4'd5) begin
            adjusted[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
         end else begin
            adjusted[4*k +: 4] = bcd[4*k +: 4];
         end
      end
      return adjusted;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one iteration per clock, input clamped to 9999.
module bin_to_bcd_seq
   import bcd_display_pkg::*;
#(
   parameter int VALUE_WIDTH = 14
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [VALUE_WIDTH-1:0] value,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            bcd,
   output logic                   overflow
);

   localparam int                     CNT_W     = $clog2(VALUE_WIDTH + 1);
   localparam logic [CNT_W-1:0]       LAST_ITER = CNT_W'(VALUE_WIDTH - 1);
   localparam logic [VALUE_WIDTH-1:0] MAX_VALUE = VALUE_WIDTH'(MAX_DISPLAY);

   state_t                 state;
   logic [VALUE_WIDTH-1:0] bin;
   logic [15:0]            acc;
   logic [CNT_W-1:0]       iter;
   logic                   overflow_pending;

   logic [VALUE_WIDTH-1:0] clamped;
   logic [15:0]            adjusted;
   logic [15:0]            acc_next;
   logic [VALUE_WIDTH-1:0] bin_next;

   // Clamp on capture, then add-3 correction followed by a one-bit left shift of {bcd,bin}.
   always_comb begin
      clamped  = (value > MAX_VALUE) ? MAX_VALUE : value;
      adjusted = dd_adjust(acc);
      acc_next = {adjusted[14:0], bin[VALUE_WIDTH-1]};
      bin_next = {bin[VALUE_WIDTH-2:0], 1'b0};
   end

   // Conversion FSM and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         bin              <= '0;
         acc              <= '0;
         iter             <= '0;
         overflow_pending <= 1'b0;
         bcd              <= '0;
         overflow         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bin              <= clamped;
                  overflow_pending <= (value > MAX_VALUE);
                  acc              <= '0;
                  iter             <= '0;
                  state            <= SHIFT;
               end
            end
            SHIFT: begin
               acc  <= acc_next;
               bin  <= bin_next;
               iter <= iter + CNT_W'(1);
               if (iter == LAST_ITER) begin
                  state <= DONE;
               end
            end
            DONE: begin
               bcd      <= acc;
               overflow <= overflow_pending;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: rtl/bcd_display_driver.sv
// Four-digit decimal display driver: change-triggered BCD conversion plus
// time-multiplexed common-anode scan with optional leading-zero blanking.
module bcd_display_driver
   import bcd_display_pkg::*;
#(
   parameter int VALUE_WIDTH  = 14,
   parameter int REFRESH_BITS = 17
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [VALUE_WIDTH-1:0] value,
   input  logic                   blank_leading_zeros,
   input  logic [3:0]             dp_in,
   output logic [3:0]             anode,
   output logic [7:0]             segment,
   output logic                   busy,
   output logic                   overflow
);

   logic                    conv_busy;
   logic                    conv_done;
   logic [15:0]             digits;
   logic [VALUE_WIDTH-1:0]  raw_value;
   logic [VALUE_WIDTH-1:0]  last_value;
   logic                    have_value;
   logic                    start;
   logic [REFRESH_BITS-1:0] scan_cnt;
   logic [1:0]              sel;
   logic [3:0]              zero_from;
   logic [3:0]              cur_digit;
   logic                    blank_digit;
   logic [3:0]              next_anode;
   logic [7:0]              next_segment;

   assign start = !conv_busy && (!have_value || (value != last_value));
   assign sel   = scan_cnt[REFRESH_BITS-1:REFRESH_BITS-2];

   bin_to_bcd_seq #(
      .VALUE_WIDTH (VALUE_WIDTH)
   ) u_conv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .value    (value),
      .busy     (conv_busy),
      .done     (conv_done),
      .bcd      (digits),
      .overflow (overflow)
   );

   // The raw (unclamped) value is remembered so an over-range input does not retrigger forever.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw_value  <= '0;
         last_value <= '0;
         have_value <= 1'b0;
      end else begin
         if (start) begin
            raw_value <= value;
         end
         if (conv_done) begin
            last_value <= raw_value;
            have_value <= 1'b1;
         end
      end
   end

   // Free-running refresh counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
      end else begin
         scan_cnt <= scan_cnt + REFRESH_BITS'(1);
      end
   end

   // zero_from[k] means digit k and every digit above it are zero.
   always_comb begin
      zero_from[3] = (digits[15:12] == 4'd0);
      zero_from[2] = zero_from[3] && (digits[11:8] == 4'd0);
      zero_from[1] = zero_from[2] && (digits[7:4] == 4'd0);
      zero_from[0] = 1'b0;
      cur_digit    = digits[4*sel +: 4];
      blank_digit  = blank_leading_zeros && zero_from[sel];
      next_anode   = ~(4'b0001 << sel);
      if (blank_digit) begin
         next_segment = {~dp_in[sel], SEG_BLANK[6:0]};
      end else begin
         next_segment = {~dp_in[sel], seg_decode(cur_digit)};
      end
   end

   // Registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         anode   <= 4'b1111;
         segment <= SEG_BLANK;
      end else begin
         anode   <= next_anode;
         segment <= next_segment;
      end
   end

   assign busy = conv_busy;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed self-checking bench for bcd_display_driver with a 4-bit refresh counter.
module tb_bcd_display_driver;

   logic        clk;
   logic        rst_n;
   logic [13:0] value;
   logic        blank_leading_zeros;
   logic [3:0]  dp_in;
   logic [3:0]  anode;
   logic [7:0]  segment;
   logic        busy;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   logic [3:0] m_cnt;
   logic [1:0] m_sel;

   bcd_display_driver #(
      .VALUE_WIDTH  (14),
      .REFRESH_BITS (4)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .value               (value),
      .blank_leading_zeros (blank_leading_zeros),
      .dp_in               (dp_in),
      .anode               (anode),
      .segment             (segment),
      .busy                (busy),
      .overflow            (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected scan position: the digit shown after an edge is the one selected before it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt <= 4'd0;
         m_sel <= 2'd0;
      end else begin
         m_cnt <= m_cnt + 4'd1;
         m_sel <= m_cnt[3:2];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // exp is {digit3, digit2, digit1, digit0} segment bytes.
   task automatic show(input string tag, input logic [31:0] exp, input int n);
      logic [3:0] ea;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ea = ~(4'b0001 << m_sel);
         chk({tag, " anode"}, {28'd0, anode}, {28'd0, ea});
         chk({tag, " segment"}, {24'd0, segment}, {24'd0, exp[m_sel*8 +: 8]});
      end
   endtask

   // Applies a value and counts busy cycles; optionally changes value on busy cycle chg_at.
   task automatic run_conv(input string tag, input logic [13:0] v, input int chg_at,
                           input logic [13:0] v2);
      int cnt;
      cnt = 0;
      value = v;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) begin
            cnt++;
            if (cnt == chg_at) value = v2;
         end else if (cnt > 0) begin
            break;
         end
      end
      chk({tag, " busy cycles"}, 32'(cnt), 32'd15);
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      value = 14'd0;
      blank_leading_zeros = 1'b0;
      dp_in = 4'b0000;
      repeat (3) @(negedge clk);
      chk("reset anode", {28'd0, anode}, 32'h0000_000F);
      chk("reset segment", {24'd0, segment}, 32'h0000_00FF);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset overflow", {31'd0, overflow}, 32'd0);

      rst_n = 1'b1;
      run_conv("initial", 14'd0, 0, 14'd0);
      show("initial zero", 32'hC0C0C0C0, 16);

      run_conv("v1234", 14'd1234, 0, 14'd0);
      chk("v1234 overflow", {31'd0, overflow}, 32'd0);
      show("v1234", 32'hF9A4B099, 16);

      run_conv("v12000", 14'd12000, 0, 14'd0);
      chk("v12000 overflow", {31'd0, overflow}, 32'd1);
      show("v12000", 32'h90909090, 16);

      run_conv("v5", 14'd5, 0, 14'd0);
      chk("v5 overflow", {31'd0, overflow}, 32'd0);
      show("v5", 32'hC0C0C092, 16);

      blank_leading_zeros = 1'b1;
      run_conv("blank7", 14'd7, 0, 14'd0);
      show("blank7", 32'hFFFFFFF8, 16);
      run_conv("blank0", 14'd0, 0, 14'd0);
      show("blank0", 32'hFFFFFFC0, 16);
      dp_in = 4'b0100;
      repeat (2) @(negedge clk);
      show("blank dp2", 32'hFF7FFFC0, 16);

      blank_leading_zeros = 1'b0;
      dp_in = 4'b0000;
      run_conv("mid42", 14'd42, 5, 14'd43);
      @(negedge clk);
      chk("mid single idle", {31'd0, busy}, 32'd1);
      show("mid42", 32'hC0C099A4, 15);
      chk("mid second done", {31'd0, busy}, 32'd0);
      show("mid43", 32'hC0C099B0, 16);

      value = 14'd50;
      cnt = 0;
      for (int i = 0; i < 40 && cnt < 7; i++) begin
         @(negedge clk);
         if (busy) cnt++;
      end
      chk("areset reach", 32'(cnt), 32'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("areset anode", {28'd0, anode}, 32'h0000_000F);
      chk("areset segment", {24'd0, segment}, 32'h0000_00FF);
      chk("areset busy", {31'd0, busy}, 32'd0);
      chk("areset overflow", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      value = 14'd99;
      rst_n = 1'b1;
      run_conv("after reset", 14'd99, 0, 14'd0);
      show("v99", 32'hC0C09090, 16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
